matvec_mult_q: RTL

Second-generation fixed-point matrix-vector engine for the LSTM autoencoder datapath. It computes y = sat(round(W·x + b)) for a row-major weight matrix streamed from external memory, with a parametric MAC lane count, an optional per-row bias, and rounding and saturation back to DATA_WIDTH Q-format. Each row result is streamed out over a valid/ready handshake so downstream activation logic can apply backpressure. The block sits between the weight SRAM controller and the gate activation units.

---
 rtl/matvec_pkg.sv | 39 +++
 rtl/matvec_mult_q_mac_lanes.sv | 46 ++++
 rtl/matvec_mult_q.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matvec_pkg.sv
// Shared types and arithmetic helpers for the matrix-vector engine.
package matvec_pkg;

  // One-hot controller states.
  typedef enum logic [5:0] {
    StIdle    = 6'b000001,
    StLoad    = 6'b000010,
    StFetch   = 6'b000100,
    StCompute = 6'b001000,
    StOutput  = 6'b010000,
    StDone    = 6'b100000
  } state_e;

  // Accumulator width: full product width plus headroom for MAX_COLS terms.
  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned max_cols);
    return 2 * data_width + $clog2(max_cols);
  endfunction

  // Round half up by 2^frac_bits, then clamp to a data_width signed word.
  // Works in a wide domain; the caller keeps the low data_width bits.
  function automatic logic signed [127:0] round_sat(input logic signed [127:0] sum,
                                                    input int unsigned frac_bits,
                                                    input int unsigned data_width);
    logic signed [127:0] rounded;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    rounded = (sum + (128'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    hi      = (128'sd1 <<< (data_width - 1)) - 128'sd1;
    lo      = -(128'sd1 <<< (data_width - 1));
    if (rounded > hi) begin
      return hi;
    end else if (rounded < lo) begin
      return lo;
    end
    return rounded;
  endfunction

endpackage

// File: rtl/matvec_mult_q_mac_lanes.sv
// LANES-wide signed dot product with per-lane enables and a balanced adder tree.
module mac_lanes
  import matvec_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [LANES*DATA_WIDTH-1:0]                  a,
  input  logic [LANES*DATA_WIDTH-1:0]                  b,
  input  logic [LANES-1:0]                             lane_en,
  output logic signed [2*DATA_WIDTH+$clog2(LANES)-1:0] sum
);

  localparam int unsigned OutW   = 2 * DATA_WIDTH + $clog2(LANES);
  localparam int unsigned ProdW  = 2 * DATA_WIDTH;
  localparam int unsigned Leaves = 1 << $clog2(LANES);

  // Heap-ordered tree: leaves at [Leaves-1 +: Leaves], root at node[0].
  logic signed [OutW-1:0] node [2*Leaves-1];

  // Masked products into the leaves, then reduce pairwise towards the root.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] a_l;
    logic signed [DATA_WIDTH-1:0] b_l;
    logic signed [ProdW-1:0]      prod;
    a_l  = '0;
    b_l  = '0;
    prod = '0;
    for (int i = 0; i < int'(2 * Leaves - 1); i++) begin
      node[i] = '0;
    end
    for (int l = 0; l < int'(LANES); l++) begin
      a_l  = a[l*DATA_WIDTH +: DATA_WIDTH];
      b_l  = b[l*DATA_WIDTH +: DATA_WIDTH];
      prod = ProdW'(a_l) * ProdW'(b_l);
      if (lane_en[l]) begin
        node[int'(Leaves) - 1 + l] = OutW'(prod);
      end
    end
    for (int i = int'(Leaves) - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    sum = node[0];
  end

endmodule

// File: rtl/matvec_mult_q.sv
// Fixed-point matrix-vector engine: y = sat(round(W*x + b)), one row result per handshake.
module matvec_mult_q
  import matvec_pkg::*;
#(
  parameter int unsigned MAX_ROWS   = 64,
  parameter int unsigned MAX_COLS   = 64,
  parameter int unsigned BANDWIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 14,
  parameter int unsigned LANES      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [$clog2(MAX_ROWS):0]             num_rows,
  input  logic [$clog2(MAX_COLS):0]             num_cols,
  input  logic                                  bias_en,
  input  logic                                  vector_we,
  input  logic [$clog2(MAX_COLS)-1:0]           vector_base_addr,
  input  logic [DATA_WIDTH*BANDWIDTH-1:0]       vector_in,
  input  logic                                  bias_we,
  input  logic [$clog2(MAX_ROWS)-1:0]           bias_addr,
  input  logic [DATA_WIDTH-1:0]                 bias_in,
  output logic [$clog2(MAX_ROWS*MAX_COLS)-1:0]  matrix_addr,
  output logic                                  matrix_req,
  input  logic [DATA_WIDTH*BANDWIDTH-1:0]       matrix_data,
  input  logic                                  matrix_ready,
  output logic [DATA_WIDTH-1:0]                 result_out,
  output logic [$clog2(MAX_ROWS)-1:0]           result_row,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned RowW    = $clog2(MAX_ROWS);
  localparam int unsigned ColW    = $clog2(MAX_COLS);
  localparam int unsigned ColCntW = ColW + 1;
  localparam int unsigned AddrW   = $clog2(MAX_ROWS * MAX_COLS);
  localparam int unsigned AccW    = acc_width(DATA_WIDTH, MAX_COLS);
  localparam int unsigned ProdW   = 2 * DATA_WIDTH + $clog2(LANES);
  localparam int unsigned Chunks  = BANDWIDTH / LANES;
  localparam int unsigned ChunkW  = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam int          LanesI  = int'(LANES);
  localparam int          BwI     = int'(BANDWIDTH);

  state_e state_q, state_d;

  logic [RowW:0]                  rows_q, rows_d;
  logic [ColCntW-1:0]             cols_q, cols_d;
  logic                           bias_en_q, bias_en_d;
  logic [RowW-1:0]                row_q, row_d;
  logic [ColCntW-1:0]             col_q, col_d;
  logic [ChunkW-1:0]              chunk_q, chunk_d;
  logic [DATA_WIDTH*BANDWIDTH-1:0] mdata_q, mdata_d;
  logic signed [AccW-1:0]         acc_q, acc_d;
  logic [DATA_WIDTH-1:0]          result_q, result_d;
  logic                           vec_loaded_q, vec_loaded_d;

  // Operand stores; contents are meaningful only after being written.
  logic [DATA_WIDTH-1:0] vec_mem  [MAX_COLS];
  logic [DATA_WIDTH-1:0] bias_mem [MAX_ROWS];

  logic                         wr_open;
  logic [ColCntW-1:0]           vec_cols;
  logic                         vec_final_wr;
  logic                         last_chunk;
  logic                         last_block;
  logic                         last_row;
  int                           rem;
  int                           nchunks;
  int                           lane_base;
  logic [LANES*DATA_WIDTH-1:0]  lane_w;
  logic [LANES*DATA_WIDTH-1:0]  lane_x;
  logic [LANES-1:0]             lane_en;
  logic signed [ProdW-1:0]      mac_sum;
  logic signed [AccW-1:0]       acc_sum;
  logic signed [127:0]          row_sum;

  mac_lanes #(
    .LANES      (LANES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mac_lanes (
    .a       (lane_w),
    .b       (lane_x),
    .lane_en (lane_en),
    .sum     (mac_sum)
  );

  // Write-window decode and the "vector fully loaded" condition.
  always_comb begin
    wr_open      = (state_q == StIdle) || (state_q == StLoad);
    // Before start the column count is not latched yet, so compare against the live input.
    vec_cols     = (state_q == StIdle) ? num_cols : cols_q;
    vec_final_wr = wr_open && vector_we &&
                   (int'(vector_base_addr) + BwI >= int'(vec_cols));
    vec_loaded_d = vec_loaded_q;
    if (state_q == StDone) begin
      vec_loaded_d = 1'b0;
    end else if (vec_final_wr) begin
      vec_loaded_d = 1'b1;
    end
  end

  // Vector and bias register files (not reset).
  always_ff @(posedge clk) begin
    if (wr_open && vector_we) begin
      for (int i = 0; i < BwI; i++) begin
        vec_mem[ColW'(int'(vector_base_addr) + i)] <= vector_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (wr_open && bias_we) begin
      bias_mem[bias_addr] <= bias_in;
    end
  end

  // Block/chunk bookkeeping and lane operand selection for the current chunk.
  always_comb begin
    rem = int'(cols_q) - int'(col_q);
    if (rem > BwI) begin
      rem = BwI;
    end
    nchunks    = (rem + LanesI - 1) / LanesI;
    last_chunk = int'(chunk_q) >= nchunks - 1;
    last_block = int'(col_q) + BwI >= int'(cols_q);
    last_row   = int'(row_q) + 1 >= int'(rows_q);
    lane_base  = int'(col_q) + int'(chunk_q) * LanesI;
    lane_w     = '0;
    lane_x     = '0;
    lane_en    = '0;
    for (int l = 0; l < LanesI; l++) begin
      lane_w[l*DATA_WIDTH +: DATA_WIDTH] =
          mdata_q[(int'(chunk_q) * LanesI + l) * int'(DATA_WIDTH) +: DATA_WIDTH];
      lane_x[l*DATA_WIDTH +: DATA_WIDTH] = vec_mem[ColW'(lane_base + l)];
      lane_en[l] = (lane_base + l) < int'(cols_q);
    end
  end

  // Running sum including this chunk, plus the optional bias aligned to the product scale.
  always_comb begin
    acc_sum = acc_q + AccW'(mac_sum);
    row_sum = 128'(acc_sum);
    if (bias_en_q) begin
      row_sum = row_sum + (128'($signed(bias_mem[row_q])) <<< FRAC_BITS);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (num_rows == '0 || num_cols == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (vec_loaded_q) state_d = StFetch;
      end
      StFetch: begin
        if (matrix_ready) state_d = StCompute;
      end
      StCompute: begin
        if (last_chunk) state_d = last_block ? StOutput : StFetch;
      end
      StOutput: begin
        if (result_ready) state_d = last_row ? StDone : StFetch;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: run config, counters, fetched block, accumulator, result.
  always_comb begin
    rows_d    = rows_q;
    cols_d    = cols_q;
    bias_en_d = bias_en_q;
    row_d     = row_q;
    col_d     = col_q;
    chunk_d   = chunk_q;
    mdata_d   = mdata_q;
    acc_d     = acc_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rows_d    = num_rows;
          cols_d    = num_cols;
          bias_en_d = bias_en;
          row_d     = '0;
          col_d     = '0;
          chunk_d   = '0;
          acc_d     = '0;
        end
      end
      StFetch: begin
        if (matrix_ready) begin
          mdata_d = matrix_data;
          chunk_d = '0;
        end
      end
      StCompute: begin
        acc_d = acc_sum;
        if (last_chunk) begin
          if (last_block) begin
            result_d = DATA_WIDTH'(round_sat(row_sum, FRAC_BITS, DATA_WIDTH));
          end else begin
            col_d = col_q + ColCntW'(BANDWIDTH);
          end
        end else begin
          chunk_d = chunk_q + ChunkW'(1);
        end
      end
      StOutput: begin
        if (result_ready && !last_row) begin
          row_d = row_q + RowW'(1);
          col_d = '0;
          acc_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q       <= '0;
      cols_q       <= '0;
      bias_en_q    <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      chunk_q      <= '0;
      mdata_q      <= '0;
      acc_q        <= '0;
      result_q     <= '0;
      vec_loaded_q <= 1'b0;
    end else begin
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      bias_en_q    <= bias_en_d;
      row_q        <= row_d;
      col_q        <= col_d;
      chunk_q      <= chunk_d;
      mdata_q      <= mdata_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
      vec_loaded_q <= vec_loaded_d;
    end
  end

  // Outputs decoded from state or taken straight from registers.
  always_comb begin
    busy         = (state_q != StIdle);
    matrix_req   = (state_q == StFetch);
    result_valid = (state_q == StOutput);
    done         = (state_q == StDone);
    matrix_addr  = AddrW'(row_q) * AddrW'(cols_q) + AddrW'(col_q);
    result_out   = result_q;
    result_row   = row_q;
  end

endmodule
